vga_pixel_reader: RTL and testbench

//  Read-side consumer of the 18-bit async pixel FIFO, in the video clock domain.

---
 rtl/vga_pixel_reader.sv | 104 ++++++++++
 tb/tb_vga_pixel_reader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_reader.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pixel_reader
//  Purpose  : Video-domain reader for the async pixel FIFO. A 2-entry prefetch
//             buffer hides the FIFO read latency and serves one pixel per
//             pix_req, with horizontal position and underflow tracking.
//  Revision : 1.0
// ============================================================================
module vga_pixel_reader #(
   parameter int WIDTH    = 18,
   parameter int H_ACTIVE = 640
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   output logic             fifo_rd,
   input  logic [WIDTH-1:0] fifo_data,
   input  logic             line_start,
   input  logic             pix_req,
   output logic [WIDTH-1:0] pixel,
   output logic [9:0]       pix_x,
   output logic             underflow,
   input  logic             underflow_clr,
   output logic [15:0]      uf_count
);

   localparam logic [9:0] c_H_ACTIVE = 10'(H_ACTIVE);

   logic [WIDTH-1:0] r_buf [0:1];
   logic [1:0]       r_count;
   logic             r_inflight;

   logic             w_active;
   logic             w_pop;
   logic             w_starve;
   logic [2:0]       w_occ;

   // A request coinciding with line_start is pixel 0 of the new line.
   assign w_active = line_start | (pix_x < c_H_ACTIVE);
   assign w_pop    = pix_req & w_active & (r_count != 2'd0);
   assign w_starve = pix_req & w_active & (r_count == 2'd0);

   // Occupancy after this cycle, counting the word already in flight.
   assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign fifo_rd = ~rst & ~fifo_empty & (w_occ < 3'd2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count    <= 2'd0;
         r_inflight <= 1'b0;
         r_buf[0]   <= '0;
         r_buf[1]   <= '0;
         pixel      <= '0;
         pix_x      <= 10'd0;
         underflow  <= 1'b0;
         uf_count   <= 16'd0;
      end else begin
         r_inflight <= fifo_rd;

         // Entry 0 is always the head; entries shift down on a pop.
         case ({w_pop, r_inflight})
            2'b10: begin
               r_buf[0] <= r_buf[1];
               r_count  <= r_count - 2'd1;
            end
            2'b01: begin
               r_buf[r_count[0]] <= fifo_data;
               r_count           <= r_count + 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_buf[0] <= fifo_data;
               end else begin
                  r_buf[0] <= r_buf[1];
                  r_buf[1] <= fifo_data;
               end
            end
            default: ;
         endcase

         if (pix_req) begin
            pixel <= w_pop ? r_buf[0] : '0;
         end

         if (line_start) begin
            pix_x <= pix_req ? 10'd1 : 10'd0;
         end else if (pix_req && (pix_x < c_H_ACTIVE)) begin
            pix_x <= pix_x + 10'd1;
         end

         if (underflow_clr) begin
            underflow <= 1'b0;
            uf_count  <= 16'd0;
         end else if (w_starve) begin
            underflow <= 1'b1;
            if (uf_count != 16'hFFFF) begin
               uf_count <= uf_count + 16'd1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_pixel_reader
//  Purpose  : Directed and randomized checks of vga_pixel_reader against a
//             queue-based model of the prefetch buffer and FIFO source.
//  Revision : 1.0
// ============================================================================
module tb_vga_pixel_reader;

   localparam int WIDTH    = 18;
   localparam int H_ACTIVE = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             fifo_empty = 1'b1;
   logic             fifo_rd;
   logic [WIDTH-1:0] fifo_data = '0;
   logic             line_start = 1'b0;
   logic             pix_req = 1'b0;
   logic [WIDTH-1:0] pixel;
   logic [9:0]       pix_x;
   logic             underflow;
   logic             underflow_clr = 1'b0;
   logic [15:0]      uf_count;

   vga_pixel_reader #(.WIDTH(WIDTH), .H_ACTIVE(H_ACTIVE)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
      .fifo_data(fifo_data), .line_start(line_start), .pix_req(pix_req),
      .pixel(pixel), .pix_x(pix_x), .underflow(underflow),
      .underflow_clr(underflow_clr), .uf_count(uf_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Source FIFO contents and reference model state
   logic [WIDTH-1:0] src [$];
   bit               force_empty = 1'b0;
   logic [WIDTH-1:0] mq [$];
   bit               minf = 1'b0;
   logic [WIDTH-1:0] mpix = '0;
   int               mx = 0;
   bit               mu = 1'b0;
   int               mufc = 0;
   int               rd_pulses = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      minf = 1'b0;
      mpix = '0;
      mx   = 0;
      mu   = 1'b0;
      mufc = 0;
   endtask

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) src.push_back(WIDTH'($urandom));
   endtask

   // One clock cycle: entered and left 1 time unit after a rising edge.
   task automatic step(input bit r, input bit ls, input bit req, input bit clr);
      bit active, pop, starve, exp_rd;
      int occ;
      logic [WIDTH-1:0] arriving;
      rst = r; line_start = ls; pix_req = req; underflow_clr = clr;
      fifo_empty = force_empty || (src.size() == 0);
      if (r) model_reset();
      #1;
      active = ls || (mx < H_ACTIVE);
      pop    = req && active && (mq.size() != 0);
      starve = req && active && (mq.size() == 0);
      occ    = mq.size() + int'(minf) - int'(pop);
      exp_rd = !r && !fifo_empty && (occ < 2);
      chk("fifo_rd", 32'(fifo_rd), 32'(exp_rd));
      chk("pixel", 32'(pixel), 32'(mpix));
      chk("pix_x", 32'(pix_x), 32'(mx));
      chk("underflow", 32'(underflow), 32'(mu));
      chk("uf_count", 32'(uf_count), 32'(mufc));
      if (fifo_rd) rd_pulses++;
      arriving = fifo_data;
      @(posedge clk);
      if (!r) begin
         if (req) mpix = pop ? mq[0] : '0;
         if (pop) void'(mq.pop_front());
         if (minf) mq.push_back(arriving);
         minf = exp_rd;
         if (ls) mx = req ? 1 : 0;
         else if (req && mx < H_ACTIVE) mx++;
         if (clr) begin
            mu = 1'b0; mufc = 0;
         end else if (starve) begin
            mu = 1'b1;
            if (mufc != 16'hFFFF) mufc++;
         end
      end
      #1;
      if (exp_rd) fifo_data = src.pop_front();
      else fifo_data = WIDTH'($urandom);
   endtask

   initial begin
      @(posedge clk); #1;
      // Reset state
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);

      // Prefetch fills exactly two entries
      push_words(4);
      rd_pulses = 0;
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
      chk("prefetch_rd_pulses", 32'(rd_pulses), 32'd2);

      // Back-to-back requests with a continuously fed FIFO
      push_words(12);
      for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      chk("stream_pix_x", 32'(pix_x), 32'd8);
      chk("stream_underflow", 32'(underflow), 32'd0);

      // Drain, then starve three requests
      force_empty = 1'b1;
      step(0, 1, 0, 0);
      for (int i = 0; i < 2; i++) step(0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      chk("starve_uf_count", 32'(uf_count), 32'd3);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      chk("clr_uf_count", 32'(uf_count), 32'd0);

      // Requests past the end of the active line
      force_empty = 1'b0;
      src.delete();
      push_words(16);
      step(0, 1, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
      for (int i = 0; i < H_ACTIVE + 2; i++) step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      chk("eol_pix_x", 32'(pix_x), 32'(H_ACTIVE));
      step(0, 1, 1, 0);
      step(0, 0, 0, 0);
      chk("restart_pix_x", 32'(pix_x), 32'd1);

      // Reset while a read is in flight
      src.delete();
      force_empty = 1'b1;
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
      force_empty = 1'b0;
      push_words(4);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

      // Saturation of the starvation counter
      src.delete();
      force_empty = 1'b1;
      step(0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
      force dut.uf_count = 16'hFFFE;
      #1;
      release dut.uf_count;
      mufc = 16'hFFFE;
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      chk("uf_saturate", 32'(uf_count), 32'hFFFF);

      // Randomized traffic
      force_empty = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (src.size() < 6 && $urandom_range(0, 2) != 0) push_words(1);
         force_empty = ($urandom_range(0, 9) < 2);
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 29) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
